// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer: tracks pixel row/col in a frame and flags stride-aligned window completions
module pool_window_sequencer #(
  parameter int bitwidth    = 8,
  parameter int filterWidth = 3,
  parameter int imageWidth  = 8,
  parameter int imageHeight = 8,
  parameter int stride      = 1,
  localparam int CW = imageWidth  > 1 ? $clog2(imageWidth)  : 1,
  localparam int RW = imageHeight > 1 ? $clog2(imageHeight) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [bitwidth-1:0] data_in,
  input  logic                isValid,
  output logic [bitwidth-1:0] data_out,
  output logic                data_valid,
  output logic                window_valid,
  output logic [CW-1:0]       col_out,
  output logic [RW-1:0]       row_out,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);
  localparam int PW = stride > 1 ? $clog2(stride) : 1;
  localparam logic [CW-1:0] CMAX = CW'(imageWidth - 1);
  localparam logic [RW-1:0] RMAX = RW'(imageHeight - 1);
  localparam logic [CW-1:0] CF   = CW'(filterWidth - 1);
  localparam logic [RW-1:0] RF   = RW'(filterWidth - 1);
  localparam logic [PW-1:0] SMAX = PW'(stride - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] cph, rph;
  logic accept, col_last, row_last, win;

  always_comb begin
    accept   = state == RUN && isValid;
    col_last = col == CMAX;
    row_last = row == RMAX;
    win      = col >= CF && row >= RF && cph == '0 && rph == '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      cph          <= '0;
      rph          <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      window_valid <= 1'b0;
      col_out      <= '0;
      row_out      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      data_valid   <= accept;
      window_valid <= accept && win;
      frame_done   <= accept && col_last && row_last;
      overrun      <= isValid && state != RUN;
      if (accept) begin
        data_out <= data_in;
        col_out  <= col;
        row_out  <= row;
      end
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          col   <= '0;
          row   <= '0;
          cph   <= '0;
          rph   <= '0;
        end
        RUN: if (accept) begin
          col <= col_last ? '0 : col + 1'b1;
          // phases only advance once the window edge has been reached
          cph <= col_last ? '0 : (col >= CF ? (cph == SMAX ? '0 : cph + 1'b1) : cph);
          if (col_last) begin
            row <= row_last ? '0 : row + 1'b1;
            rph <= row >= RF ? (rph == SMAX ? '0 : rph + 1'b1) : rph;
          end
          if (col_last && row_last) state <= DONE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pool_window_sequencer.sv
// tb_pool_window_sequencer: scoreboard bench; driver queues expected pixels, negedge monitor checks them
module tb_pool_window_sequencer;
  localparam int W = 8, H = 8, F = 3, S = 1;
  logic clock = 0, reset = 1, start = 0, isValid = 0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out, d3_do, d2_do;
  logic [2:0] col_out, row_out, d3_c, d3_r, d2_c, d2_r;
  logic data_valid, window_valid, busy, frame_done, overrun;
  logic d3_dv, d3_wv, d3_b, d3_fd, d3_ov, d2_dv, d2_wv, d2_b, d2_fd, d2_ov;

  always #5 clock = ~clock;

  pool_window_sequencer dut (.clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .isValid(isValid), .data_out(data_out), .data_valid(data_valid), .window_valid(window_valid),
    .col_out(col_out), .row_out(row_out), .busy(busy), .frame_done(frame_done), .overrun(overrun));
  pool_window_sequencer #(.filterWidth(3), .stride(3)) dut3 (.clock(clock), .reset(reset),
    .start(start), .data_in(data_in), .isValid(isValid), .data_out(d3_do), .data_valid(d3_dv),
    .window_valid(d3_wv), .col_out(d3_c), .row_out(d3_r), .busy(d3_b), .frame_done(d3_fd),
    .overrun(d3_ov));
  pool_window_sequencer #(.filterWidth(2), .stride(2)) dut2 (.clock(clock), .reset(reset),
    .start(start), .data_in(data_in), .isValid(isValid), .data_out(d2_do), .data_valid(d2_dv),
    .window_valid(d2_wv), .col_out(d2_c), .row_out(d2_r), .busy(d2_b), .frame_done(d2_fd),
    .overrun(d2_ov));

  typedef struct {int d; int c; int r; bit w; bit f;} exp_t;
  exp_t q[$];
  int q3[$];
  int nchk = 0, nerr = 0, ovr_cnt = 0, exp_ovr = 0;
  int win_cnt, first_win, last_win, w3_cnt = 0, w2_cnt = 0;
  int hold_d = 0, hold_c = 0, hold_r = 0;
  bit busy_next = 0, aux_en = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pixel(input int d);
    int r, c;
    r = (d - 1) / W;
    c = (d - 1) % W;
    isValid = 1;
    data_in = 8'(d);
    q.push_back(exp_t'{d, c, r, r >= F-1 && c >= F-1 && (r-(F-1)) % S == 0 && (c-(F-1)) % S == 0,
                       r == H-1 && c == W-1});
    tick();
    isValid = 0;
    data_in = 'x;
  endtask

  task automatic frame(input int stall_at, input bit sv, input bit pv);
    win_cnt = 0; first_win = -1; last_win = -1;
    start = 1; isValid = sv; data_in = 'x;
    if (sv) exp_ovr++;
    tick();
    start = 0; isValid = 0;
    for (int i = 1; i <= W*H; i++) begin
      pixel(i);
      if (i == stall_at) tick();
    end
    if (pv) begin
      isValid = 1; data_in = 8'hEE;
      tick(); tick();
      isValid = 0; data_in = 'x;
      exp_ovr += 2;
    end else tick();
  endtask

  task automatic frame_checks();
    tick(); tick();
    chk("win_cnt", win_cnt, 36);
    chk("first_win", first_win, 19);
    chk("last_win", last_win, 64);
    chk("drain", q.size(), 0);
    chk("overrun_cnt", ovr_cnt, exp_ovr);
  endtask

  always @(negedge clock) if (!reset) begin
    if (busy_next) begin
      chk("busy_drop", busy, 0);
      busy_next = 0;
    end
    if (overrun) ovr_cnt++;
    if (data_valid) begin
      if (q.size() == 0) chk("unexpected_valid", data_out, 0 - 1);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("data", data_out, e.d);
        chk("col", col_out, e.c);
        chk("row", row_out, e.r);
        chk("win", window_valid, e.w);
        chk("done", frame_done, e.f);
      end
      if (window_valid) begin
        win_cnt++;
        if (first_win < 0) first_win = data_out;
        last_win = data_out;
      end
      if (frame_done) begin
        chk("busy_at_done", busy, 1);
        busy_next = 1;
      end
      hold_d = data_out; hold_c = col_out; hold_r = row_out;
    end else begin
      chk("hold_data", data_out, hold_d);
      chk("hold_pos", {col_out, row_out}, {3'(hold_c), 3'(hold_r)});
      chk("idle_flags", {window_valid, frame_done}, 0);
    end
    if (aux_en && d3_wv) begin
      w3_cnt++;
      if (q3.size() == 0) chk("w3_extra", d3_do, 0 - 1);
      else chk("w3_data", d3_do, q3.pop_front());
    end
    if (aux_en && d2_wv) begin
      w2_cnt++;
      chk("w2_pos", ((d2_do - 1) % 8) % 2 == 1 && ((d2_do - 1) / 8) % 2 == 1, 1);
    end
  end

  task automatic check_zero(input string n);
    chk(n, {data_out, data_valid, window_valid, col_out, row_out, busy, frame_done, overrun}, 0);
  endtask

  initial begin
    #2 check_zero("reset_state");
    tick(); tick();
    reset = 0;
    tick();
    // pixel offered in IDLE without start
    isValid = 1; data_in = 8'h55; exp_ovr++;
    tick();
    isValid = 0; data_in = 'x;
    tick(); tick();
    chk("overrun_idle", ovr_cnt, exp_ovr);
    // defaults plus stride-3 and stride-2 variants on the same stream
    q3 = '{19, 22, 43, 46};
    aux_en = 1;
    frame(0, 0, 0);
    frame_checks();
    aux_en = 0;
    chk("w3_cnt", w3_cnt, 4);
    chk("w3_left", q3.size(), 0);
    chk("w2_cnt", w2_cnt, 16);
    // one-cycle stall after pixel 19
    frame(19, 0, 0);
    frame_checks();
    // asynchronous reset mid-frame after pixel 30
    start = 1; tick(); start = 0;
    for (int i = 1; i <= 30; i++) pixel(i);
    tick();
    reset = 1;
    #1 check_zero("async_reset");
    chk("reset_drain", q.size(), 0);
    hold_d = 0; hold_c = 0; hold_r = 0; busy_next = 0;
    tick();
    reset = 0;
    tick();
    frame(0, 0, 0);
    frame_checks();
    // pixels offered during DONE and the following IDLE cycle
    frame(0, 0, 1);
    frame_checks();
    // start together with isValid
    frame(0, 1, 0);
    frame_checks();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
